// File: rtl/pixel_pkg.sv
// Shared pixel types and defaults for the Sobel front-end pipeline.
package pixel_pkg;

    localparam int unsigned PIX_W_DEF = 8;
    localparam int unsigned SIZE_DEF  = 100;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    // Modulo-n increment used for row counters that wrap at frame end.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v == n - 32'd1) ? 32'd0 : v + 32'd1;
    endfunction

endpackage

// File: rtl/pixel_row_packer_if.sv
// Pixel-stream input and parallel-row output bundle of the row packer.
interface pixel_row_packer_if
    import pixel_pkg::*;
#(
    parameter int unsigned SIZE  = SIZE_DEF,
    parameter int unsigned PIX_W = PIX_W_DEF,
    parameter int unsigned IDX_W = $clog2(SIZE)
);
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_sof;
    logic             pix_ready;
    logic [PIX_W-1:0] row_out [SIZE-1:0];
    logic             row_valid;
    logic             row_ready;
    logic [IDX_W-1:0] row_idx;
    logic             row_last;
    logic             sof_err;

    modport master (
        input  pix_in, pix_valid, pix_sof, row_ready,
        output pix_ready, row_out, row_valid, row_idx, row_last, sof_err
    );

    modport slave (
        output pix_in, pix_valid, pix_sof, row_ready,
        input  pix_ready, row_out, row_valid, row_idx, row_last, sof_err
    );
endinterface

// File: rtl/pixel_row_packer_row_buffer.sv
// One row of SIZE pixel registers with column write and whole-row clear.
module row_buffer
    import pixel_pkg::*;
#(
    parameter int unsigned SIZE   = SIZE_DEF,
    parameter int unsigned PIX_W  = PIX_W_DEF,
    parameter int unsigned ADDR_W = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  din,
    output logic [PIX_W-1:0]  row [SIZE-1:0]
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(SIZE); k++) row[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < int'(SIZE); k++) row[k] <= '0;
        end else if (we) begin
            row[addr] <= din;
        end
    end

endmodule

// File: rtl/pixel_row_packer.sv
// Packs a raster pixel stream into full parallel rows via a ping-pong pair of row buffers.
module pixel_row_packer
    import pixel_pkg::*;
#(
    parameter int unsigned SIZE  = SIZE_DEF,
    parameter int unsigned PIX_W = PIX_W_DEF,
    parameter int unsigned IDX_W = $clog2(SIZE)
) (
    input logic               clk,
    input logic               rst,
    pixel_row_packer_if.master bus
);

    logic [1:0]       full;
    logic             wr_sel;
    logic             rd_sel;
    logic [IDX_W-1:0] col;
    logic [IDX_W-1:0] wr_row;
    logic [IDX_W-1:0] tag [2];
    logic [PIX_W-1:0] row_a [SIZE-1:0];
    logic [PIX_W-1:0] row_b [SIZE-1:0];

    logic             accept;
    logic             xfer;
    logic             last;
    logic [IDX_W-1:0] wcol;
    logic [IDX_W-1:0] wrow;

    assign bus.pix_ready = !full[wr_sel];
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign xfer          = full[rd_sel] && bus.row_ready;

    // A frame-start pixel restarts both counters, overwriting any partial row.
    assign wcol = bus.pix_sof ? '0 : col;
    assign wrow = bus.pix_sof ? '0 : wr_row;
    assign last = (wcol == IDX_W'(SIZE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full        <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            col         <= '0;
            wr_row      <= '0;
            tag[0]      <= '0;
            tag[1]      <= '0;
            bus.sof_err <= 1'b0;
        end else begin
            if (accept) begin
                if (last) begin
                    full[wr_sel] <= 1'b1;
                    tag[wr_sel]  <= wrow;
                    wr_sel       <= !wr_sel;
                    col          <= '0;
                    wr_row       <= IDX_W'(wrap_inc(32'(wrow), SIZE));
                end else begin
                    col    <= wcol + IDX_W'(1);
                    wr_row <= wrow;
                end
            end
            // Completion targets an empty buffer, transfer a full one: never the same.
            if (xfer) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= !rd_sel;
            end
            bus.sof_err <= accept && bus.pix_sof && (col != '0);
        end
    end

    row_buffer #(.SIZE(SIZE), .PIX_W(PIX_W), .ADDR_W(IDX_W)) u_buf0 (
        .clk  (clk),
        .rst  (rst),
        .we   (accept && !wr_sel),
        .clr  (xfer && !rd_sel),
        .addr (wcol),
        .din  (bus.pix_in),
        .row  (row_a)
    );

    row_buffer #(.SIZE(SIZE), .PIX_W(PIX_W), .ADDR_W(IDX_W)) u_buf1 (
        .clk  (clk),
        .rst  (rst),
        .we   (accept && wr_sel),
        .clr  (xfer && rd_sel),
        .addr (wcol),
        .din  (bus.pix_in),
        .row  (row_b)
    );

    always_comb begin
        for (int k = 0; k < int'(SIZE); k++) begin
            bus.row_out[k] = rd_sel ? row_b[k] : row_a[k];
        end
    end

    assign bus.row_valid = full[rd_sel];
    assign bus.row_idx   = tag[rd_sel];
    assign bus.row_last  = full[rd_sel] && (tag[rd_sel] == IDX_W'(SIZE - 1));

endmodule
